rtlmeter_window_ctrl: RTL and testbench

Synthesizable measurement-window controller for the benchmark harness. Sequences when cycle counting and waveform-trace gating are active: programmable warm-up delay, bounded or open-ended measurement window, early stop and abort. Sits beside the design under test on the main clock. Exposes a stable cycle count that harness code reads at end of simulation.

---
 rtl/rtlmeter_pkg.sv | 15 +
 rtl/rtlmeter_sat_counter.sv | 28 ++
 rtl/rtlmeter_window_ctrl.sv | 120 ++++++++++++
 tb/tb_rtlmeter_window_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlmeter_pkg.sv
// Shared definitions for the measurement-window controller: state encoding
// and default counter widths.
package rtlmeter_pkg;

    localparam int DEFAULT_CNT_W  = 64;
    localparam int DEFAULT_WARM_W = 32;

    typedef enum logic [1:0] {
        WIN_IDLE    = 2'd0,
        WIN_WARMUP  = 2'd1,
        WIN_MEASURE = 2'd2,
        WIN_DONE    = 2'd3
    } window_state_e;

endpackage

// File: rtl/rtlmeter_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module rtlmeter_sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign sat = &count;

    // clear wins over enable so a restart never carries a stale increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !sat) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/rtlmeter_window_ctrl.sv
// Measurement-window sequencer: warm-up delay, bounded/open window, early stop
// and abort; gates trace output and keeps a saturating measured-cycle count.
module rtlmeter_window_ctrl
    import rtlmeter_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int WARM_W = DEFAULT_WARM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WARM_W-1:0] cfg_warmup,
    input  logic [CNT_W-1:0]  cfg_length,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    output logic              trace_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycles
);

    localparam logic [WARM_W-1:0] WARM_ONE = {{(WARM_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    window_state_e     state_q, state_d;
    logic [WARM_W-1:0] warmup_q, warm_cnt_q, warm_cnt_d, eff_warmup;
    logic [CNT_W-1:0]  length_q, cnt_next;
    logic              cfg_fire, cnt_clear, cnt_en, cnt_sat, len_match, done_d;

    // Handshake: a config beat transfers on any edge where cfg_valid && cfg_ready;
    // cfg_ready is a pure decode of state, so offers are only taken when not running.
    assign cfg_ready = (state_q == WIN_IDLE) || (state_q == WIN_DONE);
    assign cfg_fire  = cfg_valid && cfg_ready;

    // start coinciding with a handshake must see the values being offered
    assign eff_warmup = cfg_fire ? cfg_warmup : warmup_q;

    assign cnt_next  = cnt_sat ? cycles : cycles + CNT_ONE;
    assign len_match = (length_q != '0) && (cnt_next == length_q);
    assign cnt_en    = (state_q == WIN_MEASURE) && !abort;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        cnt_clear  = 1'b0;
        done_d     = 1'b0;
        if (abort) begin
            state_d   = WIN_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                WIN_IDLE, WIN_DONE: begin
                    if (start) begin
                        cnt_clear = 1'b1;
                        if (eff_warmup != '0) begin
                            state_d    = WIN_WARMUP;
                            warm_cnt_d = eff_warmup;
                        end else begin
                            state_d = WIN_MEASURE;
                        end
                    end
                end
                WIN_WARMUP: begin
                    if (stop) begin
                        state_d = WIN_DONE;
                        done_d  = 1'b1;
                    end else if (warm_cnt_q <= WARM_ONE) begin
                        state_d    = WIN_MEASURE;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q - WARM_ONE;
                    end
                end
                WIN_MEASURE: begin
                    // the current cycle is counted by cnt_en even when leaving
                    if (stop || len_match) begin
                        state_d = WIN_DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = WIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WIN_IDLE;
            warm_cnt_q <= '0;
            warmup_q   <= '0;
            length_q   <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            done       <= done_d;
            if (cfg_fire) begin
                warmup_q <= cfg_warmup;
                length_q <= cfg_length;
            end
        end
    end

    assign trace_en = (state_q == WIN_MEASURE);
    assign busy     = (state_q == WIN_WARMUP) || (state_q == WIN_MEASURE);

    rtlmeter_sat_counter #(
        .W(CNT_W)
    ) u_cycles (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycles),
        .sat    (cnt_sat)
    );

endmodule

// File: tb/tb_rtlmeter_window_ctrl.sv
// Bench for rtlmeter_window_ctrl: a full-width instance for sequencing checks
// and a 4-bit instance for counter saturation.
module tb_rtlmeter_window_ctrl;

    localparam int CNT_W    = 64;
    localparam int WARM_W   = 32;
    localparam int S_CNT_W  = 4;
    localparam int S_WARM_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              cfg_valid, cfg_ready, start, stop, abort;
    logic [WARM_W-1:0] cfg_warmup;
    logic [CNT_W-1:0]  cfg_length, cycles;
    logic              trace_en, busy, done;

    logic                s_cfg_valid, s_cfg_ready, s_start, s_stop, s_abort;
    logic [S_WARM_W-1:0] s_cfg_warmup;
    logic [S_CNT_W-1:0]  s_cfg_length, s_cycles;
    logic                s_trace_en, s_busy, s_done;

    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_v;
    int n_checks = 0;
    int n_fail   = 0;

    rtlmeter_window_ctrl #(.CNT_W(CNT_W), .WARM_W(WARM_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_warmup(cfg_warmup), .cfg_length(cfg_length), .start(start), .stop(stop),
        .abort(abort), .trace_en(trace_en), .busy(busy), .done(done), .cycles(cycles)
    );

    rtlmeter_window_ctrl #(.CNT_W(S_CNT_W), .WARM_W(S_WARM_W)) dut_small (
        .clk(clk), .rst_n(rst_n), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_warmup(s_cfg_warmup), .cfg_length(s_cfg_length), .start(s_start), .stop(s_stop),
        .abort(s_abort), .trace_en(s_trace_en), .busy(s_busy), .done(s_done), .cycles(s_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic [WARM_W-1:0] w, input logic [CNT_W-1:0] l);
        cfg_valid  = 1'b1;
        cfg_warmup = w;
        cfg_length = l;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observes cycles k0..kmax; each done pulse consumes one scoreboard entry.
    task automatic monitor_window(input int k0, input int kmax, output int first_trace,
                                  output int trace_cnt, output int done_at, output int done_cnt);
        first_trace = -1;
        trace_cnt   = 0;
        done_at     = -1;
        done_cnt    = 0;
        for (int k = k0; k <= kmax; k++) begin
            if (trace_en) begin
                if (first_trace < 0) first_trace = k;
                trace_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_done: cycles=%0d with no expected entry", cycles);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cycles !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_cycles: got %0d expected %0d", cycles, exp_v);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({trace_en, busy, done, cfg_ready} !== 4'b0001 || cycles !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: trace/busy/done/ready=%b cycles=%0d expected 0001/0",
                     {trace_en, busy, done, cfg_ready}, cycles);
        end
        n_checks++;
        if ({s_trace_en, s_busy, s_done, s_cfg_ready} !== 4'b0001 || s_cycles !== '0) begin
            n_fail++;
            $display("FAIL reset_small: got %b/%0d expected 0001/0",
                     {s_trace_en, s_busy, s_done, s_cfg_ready}, s_cycles);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bounded();
        int ft, tc, da, dc;
        drive_cfg(32'd3, 64'd10);
        exp_q.push_back(64'd10);
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || trace_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bounded_busy_t1: busy=%b trace=%b expected 1/0", busy, trace_en);
        end
        monitor_window(1, 30, ft, tc, da, dc);
        n_checks++;
        if (ft != 4 || tc != 10 || da != 14 || dc != 1) begin
            n_fail++;
            $display("FAIL bounded_timing: first=%0d len=%0d done_at=%0d pulses=%0d expected 4/10/14/1",
                     ft, tc, da, dc);
        end
        n_checks++;
        if (cycles !== 64'd10 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bounded_hold: cycles=%0d busy=%b ready=%b expected 10/0/1",
                     cycles, busy, cfg_ready);
        end
    endtask

    task automatic test_unbounded_stop();
        int ft, tc, da, dc;
        drive_cfg(32'd0, 64'd0);
        exp_q.push_back(64'd25);
        pulse_start();
        n_checks++;
        if (trace_en !== 1'b1 || cycles !== 64'd0) begin
            n_fail++;
            $display("FAIL unb_start: trace=%b cycles=%0d expected 1/0", trace_en, cycles);
        end
        repeat (24) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        monitor_window(1, 3, ft, tc, da, dc);
        n_checks++;
        if (da != 1 || dc != 1 || tc != 0 || cycles !== 64'd25) begin
            n_fail++;
            $display("FAIL unb_stop: done_at=%0d pulses=%0d trace=%0d cycles=%0d expected 1/1/0/25",
                     da, dc, tc, cycles);
        end
        exp_q.push_back(64'd5);
        pulse_start();
        n_checks++;
        if (cycles !== 64'd0 || trace_en !== 1'b1) begin
            n_fail++;
            $display("FAIL unb_restart_clear: cycles=%0d trace=%b expected 0/1", cycles, trace_en);
        end
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        monitor_window(1, 3, ft, tc, da, dc);
        n_checks++;
        if (dc != 1 || cycles !== 64'd5) begin
            n_fail++;
            $display("FAIL unb_remeasure: pulses=%0d cycles=%0d expected 1/5", dc, cycles);
        end
    endtask

    task automatic test_abort();
        int ft, tc, da, dc;
        for (int v = 0; v < 2; v++) begin
            pulse_start();
            repeat (7) tick();
            n_checks++;
            if (cycles !== 64'd7) begin
                n_fail++;
                $display("FAIL abort_pre[%0d]: cycles=%0d expected 7", v, cycles);
            end
            abort = 1'b1;
            stop  = (v == 1);
            tick();
            abort = 1'b0;
            stop  = 1'b0;
            n_checks++;
            if ({busy, trace_en, done, cfg_ready} !== 4'b0001 || cycles !== '0) begin
                n_fail++;
                $display("FAIL abort_idle[%0d]: busy/trace/done/ready=%b cycles=%0d expected 0001/0",
                         v, {busy, trace_en, done, cfg_ready}, cycles);
            end
            monitor_window(1, 5, ft, tc, da, dc);
            n_checks++;
            if (dc != 0 || tc != 0) begin
                n_fail++;
                $display("FAIL abort_no_done[%0d]: pulses=%0d trace=%0d expected 0/0", v, dc, tc);
            end
        end
    endtask

    task automatic test_saturate();
        s_cfg_valid  = 1'b1;
        s_cfg_warmup = '0;
        s_cfg_length = '0;
        tick();
        s_cfg_valid = 1'b0;
        exp_q.push_back(64'd15);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (s_cycles !== 4'd15 || s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_reach: cycles=%0d busy=%b expected 15/1", s_cycles, s_busy);
        end
        repeat (4) tick();
        s_stop = 1'b1;
        tick();
        s_stop = 1'b0;
        n_checks++;
        if (s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_done: done=%b expected 1", s_done);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({{(CNT_W-S_CNT_W){1'b0}}, s_cycles} !== exp_v) begin
            n_fail++;
            $display("FAIL sat_no_wrap: cycles=%0d expected %0d", s_cycles, exp_v);
        end
    endtask

    task automatic test_cfg_busy();
        int ft, tc, da, dc;
        drive_cfg(32'd5, 64'd8);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(64'd8);
            pulse_start();
            if (r == 0) begin
                cfg_valid  = 1'b1;
                cfg_warmup = 32'd0;
                cfg_length = 64'd3;
                start      = 1'b1;
                #1;
                n_checks++;
                if (cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cfg_ready_busy: got %b expected 0", cfg_ready);
                end
            end
            tick();
            cfg_valid = 1'b0;
            start     = 1'b0;
            monitor_window(2, 30, ft, tc, da, dc);
            n_checks++;
            if (ft != 6 || tc != 8 || da != 14 || dc != 1) begin
                n_fail++;
                $display("FAIL cfg_busy_run[%0d]: first=%0d len=%0d done_at=%0d pulses=%0d expected 6/8/14/1",
                         r, ft, tc, da, dc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ft, tc, da, dc;
        drive_cfg(32'd2, 64'd3);
        n_checks++;
        if (cycles !== 64'd8 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cfg_hold: cycles=%0d busy=%b ready=%b expected 8/0/1",
                     cycles, busy, cfg_ready);
        end
        cfg_valid  = 1'b1;
        cfg_warmup = 32'd1;
        cfg_length = 64'd4;
        exp_q.push_back(64'd4);
        pulse_start();
        cfg_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || trace_en !== 1'b0 || cycles !== 64'd0) begin
            n_fail++;
            $display("FAIL b2b_start: busy=%b trace=%b cycles=%0d expected 1/0/0", busy, trace_en, cycles);
        end
        monitor_window(1, 20, ft, tc, da, dc);
        n_checks++;
        if (ft != 2 || tc != 4 || da != 6 || dc != 1) begin
            n_fail++;
            $display("FAIL b2b_run: first=%0d len=%0d done_at=%0d pulses=%0d expected 2/4/6/1",
                     ft, tc, da, dc);
        end
    endtask

    task automatic test_reset_mid();
        drive_cfg(32'd4, 64'd0);
        pulse_start();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, trace_en, done, cfg_ready} !== 4'b0001 || cycles !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy/trace/done/ready=%b cycles=%0d expected 0001/0",
                     {busy, trace_en, done, cfg_ready}, cycles);
        end
        #1 rst_n = 1'b1;
        tick();
        pulse_start();
        n_checks++;
        if (trace_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_warmup_cleared: trace=%b busy=%b expected 1/1", trace_en, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        {cfg_valid, start, stop, abort} = '0;
        cfg_warmup = '0;
        cfg_length = '0;
        {s_cfg_valid, s_start, s_stop, s_abort} = '0;
        s_cfg_warmup = '0;
        s_cfg_length = '0;
        test_reset();
        test_bounded();
        test_unbounded_stop();
        test_abort();
        test_saturate();
        test_cfg_busy();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected results never observed, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
